// File: rtl/feature_access_pkg.sv
// Shared types and request-classification helpers for the feature access arbiter.
package feature_access_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } chan_state_e;

  localparam int unsigned FEAT_NONE = 0;
  localparam int unsigned FEAT_RSVD = '1;

  // The reserved code is all-ones at the actual feature-code width.
  function automatic logic req_invalid(input int unsigned user,
                                       input int unsigned feat,
                                       input int unsigned fw);
    return (user == 0) || (feat == FEAT_NONE) || (feat == (FEAT_RSVD >> (32 - fw)));
  endfunction

  function automatic logic req_permitted(input int unsigned user,
                                         input int unsigned feat,
                                         input int unsigned fw,
                                         input logic        busy);
    return !req_invalid(user, feat, fw) && !busy;
  endfunction

endpackage

// File: rtl/feature_access_arbiter_rr.sv
// Round-robin picker: first eligible channel at or after ptr, one-hot result.
module rr_arbiter #(
  parameter int unsigned NCH = 2,
  parameter int unsigned PW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] i_eligible,
  input  logic [PW-1:0]  i_ptr,
  output logic [NCH-1:0] o_winner
);

  logic          w_found;
  logic [PW-1:0] w_idx;

  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      w_idx = PW'((32'(i_ptr) + k) % NCH);
      if (!w_found && i_eligible[w_idx]) begin
        o_winner[w_idx] = 1'b1;
        w_found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/feature_access_arbiter.sv
// Per-channel session FSMs sharing a feature pool, one acceptance per cycle
// chosen round-robin; invalid requests are accepted and answered with a deny.
module feature_access_arbiter
  import feature_access_pkg::*;
#(
  parameter int unsigned NCH  = 2,
  parameter int unsigned UW   = 3,
  parameter int unsigned FW   = 3,
  parameter int unsigned HOLD = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      req_valid,
  input  logic [NCH*UW-1:0]   req_user,
  input  logic [NCH*FW-1:0]   req_feat,
  output logic [NCH-1:0]      req_ready,
  input  logic [NCH-1:0]      rel,
  output logic [NCH-1:0]      grant,
  output logic [NCH-1:0]      deny,
  output logic [2**FW-1:0]    feat_busy,
  output logic [UW-1:0]       disp_user,
  output logic                disp_valid
);

  localparam int unsigned NF = 2**FW;
  localparam int unsigned PW = $clog2(NCH);
  localparam int unsigned CW = $clog2(HOLD);

  chan_state_e      r_state     [NCH];
  chan_state_e      w_state_nxt [NCH];
  logic [CW-1:0]    r_cnt       [NCH];
  logic [FW-1:0]    r_feat      [NCH];
  logic [UW-1:0]    w_user      [NCH];
  logic [FW-1:0]    w_fcode     [NCH];
  logic [NCH-1:0]   r_deny;
  logic [NCH-1:0]   w_invalid;
  logic [NCH-1:0]   w_elig;
  logic [NCH-1:0]   w_win;
  logic [NCH-1:0]   w_grant;
  logic [NF-1:0]    w_feat_busy;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    w_win_idx;
  logic [UW-1:0]    r_disp_user;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign w_user[i]    = req_user[i*UW +: UW];
    assign w_fcode[i]   = req_feat[i*FW +: FW];
    assign w_invalid[i] = req_invalid(32'(w_user[i]), 32'(w_fcode[i]), FW);
    // Busy-feature requests stay ineligible so they wait instead of being denied.
    assign w_elig[i]    = !rst && req_valid[i] && (r_state[i] == ST_IDLE) &&
                          (w_invalid[i] ||
                           req_permitted(32'(w_user[i]), 32'(w_fcode[i]), FW,
                                         w_feat_busy[w_fcode[i]]));
  end

  rr_arbiter #(.NCH(NCH), .PW(PW)) u_rr (
    .i_eligible (w_elig),
    .i_ptr      (r_ptr),
    .o_winner   (w_win)
  );

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NCH; i++) begin
      if (rst) r_state[i] <= ST_IDLE;
      else     r_state[i] <= w_state_nxt[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        ST_IDLE:   if (w_win[i] && !w_invalid[i]) w_state_nxt[i] = ST_ACTIVE;
        ST_ACTIVE: if (rel[i] || (r_cnt[i] == CW'(HOLD - 1))) w_state_nxt[i] = ST_IDLE;
        default:   w_state_nxt[i] = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_grant     = '0;
    w_feat_busy = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (r_state[i] == ST_ACTIVE) begin
        w_grant[i]             = 1'b1;
        w_feat_busy[r_feat[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NCH; i++) begin
      if (rst) begin
        r_cnt[i]  <= '0;
        r_feat[i] <= '0;
        r_deny[i] <= 1'b0;
      end else begin
        r_deny[i] <= w_win[i] && w_invalid[i];
        if (r_state[i] == ST_IDLE && w_win[i] && !w_invalid[i]) begin
          r_cnt[i]  <= '0;
          r_feat[i] <= w_fcode[i];
        end else if (r_state[i] == ST_ACTIVE) begin
          r_cnt[i] <= (w_state_nxt[i] == ST_IDLE) ? '0 : r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    w_win_idx = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (w_win[i]) w_win_idx = PW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_disp_user <= '0;
    end else begin
      if (|w_win) r_ptr <= (w_win_idx == PW'(NCH - 1)) ? '0 : w_win_idx + PW'(1);
      for (int unsigned i = 0; i < NCH; i++) begin
        if (w_win[i] && !w_invalid[i]) r_disp_user <= w_user[i];
      end
    end
  end

  assign req_ready  = w_win;
  assign grant      = w_grant;
  assign deny       = r_deny;
  assign feat_busy  = w_feat_busy;
  assign disp_user  = r_disp_user;
  assign disp_valid = |w_grant;

endmodule

// File: tb/tb_feature_access_arbiter.sv
// Directed bench with a session-level reference model checked every cycle.
module tb_feature_access_arbiter;

  localparam int NCH  = 2;
  localparam int UW   = 3;
  localparam int FW   = 3;
  localparam int HOLD = 4;
  localparam int NF   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    req_valid = '0;
  logic [NCH*UW-1:0] req_user  = '0;
  logic [NCH*FW-1:0] req_feat  = '0;
  logic [NCH-1:0]    rel       = '0;
  logic [NCH-1:0]    req_ready;
  logic [NCH-1:0]    grant;
  logic [NCH-1:0]    deny;
  logic [NF-1:0]     feat_busy;
  logic [UW-1:0]     disp_user;
  logic              disp_valid;

  feature_access_arbiter #(.NCH(NCH), .UW(UW), .FW(FW), .HOLD(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_user   (req_user),
    .req_feat   (req_feat),
    .req_ready  (req_ready),
    .rel        (rel),
    .grant      (grant),
    .deny       (deny),
    .feat_busy  (feat_busy),
    .disp_user  (disp_user),
    .disp_valid (disp_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // Reference model: each channel either has a live session with cycles left, or not.
  bit             m_act  [NCH];
  int             m_left [NCH];
  int             m_feat [NCH];
  int             m_ptr  = 0;
  logic [NCH-1:0] m_deny = '0;
  int             m_disp = 0;
  logic [NCH-1:0] m_w;

  initial begin
    for (int i = 0; i < NCH; i++) begin
      m_act[i] = 0; m_left[i] = 0; m_feat[i] = 0;
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit feat_in_use(input int f);
    for (int j = 0; j < NCH; j++) if (m_act[j] && m_feat[j] == f) return 1;
    return 0;
  endfunction

  function automatic logic [NCH-1:0] model_ready();
    logic [NCH-1:0] r;
    int c, u, f;
    bit inv;
    r = '0;
    if (rst) return r;
    for (int k = 0; k < NCH; k++) begin
      c   = (m_ptr + k) % NCH;
      u   = int'(req_user[c*UW +: UW]);
      f   = int'(req_feat[c*FW +: FW]);
      inv = (u == 0) || (f == 0) || (f == NF - 1);
      if (req_valid[c] && !m_act[c] && (inv || !feat_in_use(f))) begin
        r[c] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic logic [NCH-1:0] model_grant();
    logic [NCH-1:0] g;
    for (int i = 0; i < NCH; i++) g[i] = m_act[i];
    return g;
  endfunction

  function automatic logic [NF-1:0] model_busy();
    logic [NF-1:0] b;
    b = '0;
    for (int i = 0; i < NCH; i++) if (m_act[i]) b[m_feat[i]] = 1'b1;
    return b;
  endfunction

  always @(posedge clk) begin
    m_w = model_ready();
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_act[i] = 0; m_left[i] = 0; m_feat[i] = 0;
      end
      m_ptr = 0; m_deny = '0; m_disp = 0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (m_act[i]) begin
          if (rel[i] || m_left[i] == 1) m_act[i] = 0;
          else m_left[i]--;
        end
      end
      m_deny = '0;
      for (int i = 0; i < NCH; i++) begin
        if (m_w[i]) begin
          int u, f;
          u = int'(req_user[i*UW +: UW]);
          f = int'(req_feat[i*FW +: FW]);
          if (u == 0 || f == 0 || f == NF - 1) m_deny[i] = 1'b1;
          else begin
            m_act[i] = 1; m_left[i] = HOLD; m_feat[i] = f; m_disp = u;
          end
          m_ptr = (i + 1) % NCH;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("req_ready",  req_ready,  model_ready());
      cmp("grant",      grant,      model_grant());
      cmp("deny",       deny,       m_deny);
      cmp("feat_busy",  feat_busy,  model_busy());
      cmp("disp_user",  disp_user,  m_disp);
      cmp("disp_valid", disp_valid, |model_grant());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setreq(input logic [1:0] v, input logic [2:0] u0, input logic [2:0] f0,
                        input logic [2:0] u1, input logic [2:0] f1, input logic [1:0] rl);
    req_valid = v;
    req_user  = {u1, u0};
    req_feat  = {f1, f0};
    rel       = rl;
  endtask

  int n, w;

  initial begin
    rst = 1'b1;
    tick();
    chk_en = 1;
    tick();
    rst = 1'b0;

    // Single session on ch0, feature 2
    setreq(2'b01, 3'd5, 3'd2, 3'd0, 3'd0, 2'b00);
    #1 cmp("A ready", req_ready, 2'b01);
    tick();
    setreq(2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00);
    #1;
    cmp("A grant", grant, 2'b01);
    cmp("A busy", feat_busy, 8'h04);
    cmp("A disp_user", disp_user, 3'd5);
    cmp("A disp_valid", disp_valid, 1'b1);
    n = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!grant[0]) break;
      n++;
    end
    cmp("A grant length", n, HOLD);

    // Contention on one feature, loser waits for the session to end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    setreq(2'b11, 3'd1, 3'd3, 3'd2, 3'd3, 2'b00);
    #1 cmp("B ready", req_ready, 2'b01);
    tick();
    setreq(2'b10, 3'd0, 3'd0, 3'd2, 3'd3, 2'b00);
    #1 cmp("B grant0", grant, 2'b01);
    w = 0;
    while (!req_ready[1] && w < 20) begin
      tick();
      #1;
      w++;
    end
    cmp("B wait cycles", w, HOLD);
    cmp("B no overlap", grant, 2'b00);
    tick();
    setreq(2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00);
    #1;
    cmp("B grant1", grant, 2'b10);
    cmp("B disp_user", disp_user, 3'd2);
    cmp("B busy", feat_busy, 8'h08);
    repeat (5) tick();
    setreq(2'b11, 3'd3, 3'd1, 3'd4, 3'd5, 2'b00);
    #1 cmp("B rr ch0 first", req_ready, 2'b01);
    tick();
    setreq(2'b10, 3'd0, 3'd0, 3'd4, 3'd5, 2'b00);
    #1 cmp("B rr ch1 next", req_ready, 2'b10);
    tick();
    setreq(2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00);
    #1 cmp("B both busy", feat_busy, 8'h22);
    repeat (6) tick();

    // Invalid user on ch1
    setreq(2'b10, 3'd0, 3'd0, 3'd0, 3'd1, 2'b00);
    #1 cmp("C ready", req_ready, 2'b10);
    tick();
    setreq(2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00);
    #1;
    cmp("C deny", deny, 2'b10);
    cmp("C grant", grant, 2'b00);
    cmp("C busy", feat_busy, 8'h00);
    tick();
    cmp("C deny pulse", deny, 2'b00);

    // Reserved feature, then early release (rel on idle ch1 ignored)
    setreq(2'b01, 3'd3, 3'd7, 3'd0, 3'd0, 2'b00);
    #1 cmp("D ready", req_ready, 2'b01);
    tick();
    setreq(2'b01, 3'd3, 3'd4, 3'd0, 3'd0, 2'b00);
    #1 cmp("D deny", deny, 2'b01);
    tick();
    setreq(2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00);
    #1;
    cmp("D grant", grant, 2'b01);
    cmp("D busy", feat_busy, 8'h10);
    tick();
    rel = 2'b11;
    tick();
    rel = 2'b00;
    #1;
    cmp("D released", grant, 2'b00);
    cmp("D busy clr", feat_busy, 8'h00);
    cmp("D disp_valid", disp_valid, 1'b0);
    cmp("D disp_user kept", disp_user, 3'd3);

    // Reset aborts a live session
    setreq(2'b01, 3'd6, 3'd1, 3'd0, 3'd0, 2'b00);
    tick();
    setreq(2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00);
    tick();
    #1 cmp("E grant", grant, 2'b01);
    rst = 1'b1;
    setreq(2'b10, 3'd0, 3'd0, 3'd4, 3'd1, 2'b00);
    #1 cmp("E ready in rst", req_ready, 2'b00);
    tick();
    rst = 1'b0;
    #1;
    cmp("E grant rst", grant, 2'b00);
    cmp("E deny rst", deny, 2'b00);
    cmp("E busy rst", feat_busy, 8'h00);
    cmp("E disp_user rst", disp_user, 3'd0);
    cmp("E disp_valid rst", disp_valid, 1'b0);
    cmp("E ready after", req_ready, 2'b10);
    tick();
    setreq(2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00);
    #1;
    cmp("E regrant", grant, 2'b10);
    cmp("E regrant user", disp_user, 3'd4);
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/feature_access_arbiter.md
FEATURE_ACCESS_ARBITER -- requirements
Module: feature_access_arbiter

Interface
REQ-001 The block SHALL expose parameter NCH, default 2, meaning number of entry interfaces (2..8).
REQ-002 The block SHALL expose parameter UW, default 3, meaning user-ID width per channel.
REQ-003 The block SHALL expose parameter FW, default 3, meaning feature-code width per channel; NFEAT = 2**FW - 2 usable features, codes 1..NFEAT.
REQ-004 The block SHALL expose parameter HOLD, default 16, meaning session length in clock cycles (>=2).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  reset; synchronous and active-high.
REQ-007 req_valid  in  NCH  per-channel request strobe.
REQ-008 req_user  in  NCH*UW  per-channel user ID, channel i at bits [i*UW +: UW].
REQ-009 req_feat  in  NCH*FW  per-channel feature code, same packing.
REQ-010 req_ready  out  NCH  per-channel accept; a transfer occurs when valid and ready are both 1.
REQ-011 rel  in  NCH  per-channel early session release pulse.
REQ-012 grant  out  NCH  channel holds an active session.
REQ-013 deny  out  NCH  one-cycle pulse: accepted request was rejected.
REQ-014 feat_busy  out  2**FW  one-hot-per-feature occupancy vector, bit k = feature k in use; bits 0 and 2**FW-1 are always 0.
REQ-015 disp_user  out  UW  user ID of most recent grant.
REQ-016 disp_valid  out  1  disp_user is meaningful (at least one grant is active).

Function
REQ-017 Each channel SHALL run an FSM with states IDLE and ACTIVE.
REQ-018 A request SHALL be permitted iff user != 0, feature in 1..NFEAT, and the feature bit in feat_busy is 0.
REQ-019 A request SHALL be invalid iff user == 0 or feature is 0 or 2**FW-1.
REQ-020 Eligible channels SHALL be those in IDLE with req_valid=1 whose request is either permitted or invalid; busy-feature requests SHALL wait with req_ready=0 (no deny).
REQ-021 At most one channel SHALL see req_ready=1 per cycle, chosen round-robin among eligible channels starting at pointer ptr; req_ready SHALL be combinational from registered state and inputs.
REQ-022 On each transfer ptr SHALL advance to (winner+1) mod NCH; otherwise ptr SHALL hold.
REQ-023 An accepted permitted request SHALL cause, on the next cycle: grant[i]=1, state ACTIVE, feat_busy bit set, disp_user=user, disp_valid=1, and the session counter loaded with 0.
REQ-024 An accepted invalid request SHALL cause deny[i]=1 for exactly the next cycle; state remains IDLE; no other output changes.
REQ-025 In ACTIVE the counter SHALL increment each cycle; at count HOLD-1, or on rel[i]=1, the channel SHALL return to IDLE next cycle, clearing grant[i] and the feature bit.
REQ-026 Total session length without rel SHALL be exactly HOLD cycles of grant=1.
REQ-027 A feature freed in cycle t SHALL be grantable to another channel by a request accepted in cycle t+1 at the earliest (no same-cycle reuse).
REQ-028 rel to an IDLE channel SHALL be ignored.
REQ-029 disp_valid SHALL drop to 0 when no channel is ACTIVE; disp_user SHALL retain its last value.
REQ-030 Two channels requesting the same free feature in the same cycle: only the round-robin winner SHALL be granted; the loser SHALL wait.

Reset
REQ-031 rst=1 SHALL force, on the next edge: all FSMs IDLE, counters 0, ptr 0, grant/deny/feat_busy 0, disp_user 0, disp_valid 0.
REQ-032 rst asserted mid-session SHALL abort all sessions without a deny pulse; req_ready SHALL be 0 while rst=1.

Structure
REQ-033 Package feature_access_pkg SHALL hold the channel state enum, the feature-code constants (FEAT_NONE=0, FEAT_RSVD=all-ones), and the permission/validity functions.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter (parameter NCH; inputs eligible vector and ptr; outputs one-hot winner).

Verification (NCH=2, UW=3, FW=3, HOLD=4)
REQ-035 ch0 user=5 feat=2 valid one cycle -> ready0=1; next cycle grant0=1, feat_busy=8'h04, disp_user=5; grant0 high exactly 4 cycles then 0.
REQ-036 ch0 and ch1 both request feat=3 same cycle after reset -> ch0 granted; ch1 ready=0 until ch0 session ends, then granted; ptr alternates.
REQ-037 ch1 user=0 feat=1 -> ready1=1, deny1=1 one cycle, grant1=0, feat_busy unchanged.
REQ-038 ch0 feat=7 -> deny0 pulse; ch0 feat=4 then rel0 on second ACTIVE cycle -> grant0 falls next cycle, feat_busy bit 4 clears.
REQ-039 rst asserted during active ch0 session -> next cycle all outputs 0, no deny; new request after rst deassertion granted normally.
REQ-040 ch0 session ends at cycle t while ch1 waits on same feature -> ch1 accepted no earlier than t+1, never overlapping grant on that feature.
